bert_error_integrator: RTL and testbench

Parametrised multi-lane PRBS error integrator for the front-panel BERT. It consumes the per-cycle PRBS error flags of LANES bonded receive lanes sharing one RX user clock. Per lane it maintains saturating error counters over a programmable integration window, a pattern-lock detector and a registered snapshot readout. It sits between the transceiver RX fabric interface and the register-synchronizer-fed control/status path.

---
 rtl/bert_error_integrator.sv | 219 +++++++++++++++++++++
 tb/tb_bert_error_integrator.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bert_error_integrator.sv
// ---------------------------------------------------------------------------
// bert_error_integrator
//
// Multi-lane PRBS error integrator for the front-panel BERT. A group of
// bonded receive lanes share one RX user clock. For each lane this block
// keeps a saturating error counter over a programmable integration window,
// runs a pattern-lock detector, and provides a registered snapshot readout.
// A cycle counter that is common to all lanes runs alongside the error
// counters.
//
// Ports
//   clk             RX user clock; all logic runs in this domain
//   reset           synchronous, active-high reset
//   start           pulse: clear the live counters and begin integrating
//   stop            pulse: end integration early
//   window_cycles   integration length in clk cycles (0 = run until stop)
//   prbs_err        per-lane PRBS checker error flag, one per cycle
//   lane_sel        selects which lane's snapshot error count is read out
//   rd_err_count    snapshot error count of lane_sel (1-cycle latency)
//   rd_cycles       snapshot integrated cycle count
//   rd_valid        snapshot contents are valid
//   running         integration in progress
//   done            one-cycle pulse at the end of a window
//   lane_locked     per-lane pattern lock status
//   lane_saturated  per-lane snapshot error counter is saturated
// ---------------------------------------------------------------------------
module bert_error_integrator #(
    parameter int LANES         = 2,
    parameter int COUNT_W       = 48,
    parameter int LOCK_CYCLES   = 64,
    parameter int UNLOCK_CYCLES = 16,
    localparam int SEL_W        = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [COUNT_W-1:0] window_cycles,
    input  logic [LANES-1:0]   prbs_err,
    input  logic [SEL_W-1:0]   lane_sel,
    output logic [COUNT_W-1:0] rd_err_count,
    output logic [COUNT_W-1:0] rd_cycles,
    output logic               rd_valid,
    output logic               running,
    output logic               done,
    output logic [LANES-1:0]   lane_locked,
    output logic [LANES-1:0]   lane_saturated
);

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    // Run-length counters only need to reach their thresholds.
    localparam int LOCK_W   = $clog2(LOCK_CYCLES + 1);
    localparam int UNLOCK_W = $clog2(UNLOCK_CYCLES + 1);
    localparam logic [LOCK_W-1:0]   LOCK_MAX   = LOCK_W'(LOCK_CYCLES);
    localparam logic [UNLOCK_W-1:0] UNLOCK_MAX = UNLOCK_W'(UNLOCK_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    state_t state;

    logic [COUNT_W-1:0] cyc_cnt;
    logic [COUNT_W-1:0] win_len;
    logic [COUNT_W-1:0] err_cnt  [LANES];
    logic [COUNT_W-1:0] snap_err [LANES];
    logic [COUNT_W-1:0] snap_cyc;

    logic [COUNT_W-1:0] cyc_inc;
    logic               window_end;
    logic [COUNT_W-1:0] sel_err;

    logic [LOCK_W-1:0]   clean_run [LANES];
    logic [UNLOCK_W-1:0] bad_run   [LANES];

    // The window closes on the cycle whose count brings cyc_cnt up to the
    // programmed length, so that cycle is still counted. Once cyc_cnt has
    // saturated, cyc_inc wraps to zero and can never match a non-zero
    // window, which keeps an over-long window from ending spuriously.
    assign cyc_inc    = cyc_cnt + 1'b1;
    assign window_end = (win_len != '0) && (cyc_inc == win_len);

    // Integration FSM: IDLE -> RUN -> LATCH -> IDLE.
    // A start seen in RUN restarts the window in place (and beats a
    // simultaneous stop). A start seen in LATCH is ignored; if it is still
    // asserted on the following IDLE cycle it is taken from there.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            running        <= 1'b0;
            done           <= 1'b0;
            rd_valid       <= 1'b0;
            lane_saturated <= '0;
            cyc_cnt        <= '0;
            win_len        <= '0;
            snap_cyc       <= '0;
            for (int i = 0; i < LANES; i++) begin
                err_cnt[i]  <= '0;
                snap_err[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_RUN;
                        running  <= 1'b1;
                        rd_valid <= 1'b0;
                        cyc_cnt  <= '0;
                        win_len  <= window_cycles;
                        for (int i = 0; i < LANES; i++) begin
                            err_cnt[i] <= '0;
                        end
                    end
                end

                S_RUN: begin
                    if (start) begin
                        cyc_cnt <= '0;
                        win_len <= window_cycles;
                        for (int i = 0; i < LANES; i++) begin
                            err_cnt[i] <= '0;
                        end
                    end else begin
                        if (cyc_cnt != CNT_MAX) begin
                            cyc_cnt <= cyc_inc;
                        end
                        for (int i = 0; i < LANES; i++) begin
                            if (prbs_err[i] && (err_cnt[i] != CNT_MAX)) begin
                                err_cnt[i] <= err_cnt[i] + 1'b1;
                            end
                        end
                        if (stop || window_end) begin
                            state   <= S_LATCH;
                            running <= 1'b0;
                        end
                    end
                end

                S_LATCH: begin
                    snap_cyc <= cyc_cnt;
                    for (int i = 0; i < LANES; i++) begin
                        snap_err[i]       <= err_cnt[i];
                        lane_saturated[i] <= (err_cnt[i] == CNT_MAX);
                    end
                    done     <= 1'b1;
                    rd_valid <= 1'b1;
                    state    <= S_IDLE;
                end

                default: begin
                    state   <= S_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // Lane select mux; out-of-range selects fall through to zero.
    always_comb begin
        sel_err = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_sel == SEL_W'(i)) begin
                sel_err = snap_err[i];
            end
        end
    end

    // Registered readout of the snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_err_count <= '0;
            rd_cycles    <= '0;
        end else begin
            rd_err_count <= sel_err;
            rd_cycles    <= snap_cyc;
        end
    end

    // Lock detector, independent of the integration FSM. Each lane tracks
    // the length of its current clean streak and current error streak; a
    // value of the opposite polarity zeroes the other streak. Lock is
    // declared on the cycle a clean streak reaches LOCK_CYCLES and dropped
    // on the cycle an error streak reaches UNLOCK_CYCLES. Both streak
    // counters hold at their threshold.
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_locked <= '0;
            for (int i = 0; i < LANES; i++) begin
                clean_run[i] <= '0;
                bad_run[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (prbs_err[i]) begin
                    clean_run[i] <= '0;
                    if (bad_run[i] != UNLOCK_MAX) begin
                        bad_run[i] <= bad_run[i] + 1'b1;
                        if (bad_run[i] == (UNLOCK_MAX - 1'b1)) begin
                            lane_locked[i] <= 1'b0;
                        end
                    end
                end else begin
                    bad_run[i] <= '0;
                    if (clean_run[i] != LOCK_MAX) begin
                        clean_run[i] <= clean_run[i] + 1'b1;
                        if (clean_run[i] == (LOCK_MAX - 1'b1)) begin
                            lane_locked[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bert_error_integrator.sv
// ---------------------------------------------------------------------------
// tb_bert_error_integrator
//
// Self-checking bench for bert_error_integrator. Three lanes (so that one
// lane_sel code is out of range) and 8-bit counters (so that saturation is
// reachable quickly). The reference model tracks expected counts with plain
// integers: cycles and errors seen while a window is open, and the current
// clean/error streak lengths per lane for the lock status.
// ---------------------------------------------------------------------------
module tb_bert_error_integrator;

    localparam int LANES         = 3;
    localparam int COUNT_W       = 8;
    localparam int LOCK_CYCLES   = 64;
    localparam int UNLOCK_CYCLES = 16;
    localparam int SEL_W         = 2;
    localparam int CNT_MAX       = (1 << COUNT_W) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               stop;
    logic [COUNT_W-1:0] window_cycles;
    logic [LANES-1:0]   prbs_err;
    logic [SEL_W-1:0]   lane_sel;
    logic [COUNT_W-1:0] rd_err_count;
    logic [COUNT_W-1:0] rd_cycles;
    logic               rd_valid;
    logic               running;
    logic               done;
    logic [LANES-1:0]   lane_locked;
    logic [LANES-1:0]   lane_saturated;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int               exp_cyc;
    int               exp_err [LANES];
    int               m_clean [LANES] = '{default: 0};
    int               m_bad   [LANES] = '{default: 0};
    logic [LANES-1:0] m_locked = '0;

    bert_error_integrator #(
        .LANES        (LANES),
        .COUNT_W      (COUNT_W),
        .LOCK_CYCLES  (LOCK_CYCLES),
        .UNLOCK_CYCLES(UNLOCK_CYCLES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .window_cycles (window_cycles),
        .prbs_err      (prbs_err),
        .lane_sel      (lane_sel),
        .rd_err_count  (rd_err_count),
        .rd_cycles     (rd_cycles),
        .rd_valid      (rd_valid),
        .running       (running),
        .done          (done),
        .lane_locked   (lane_locked),
        .lane_saturated(lane_saturated)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int x);
        return (x > CNT_MAX) ? CNT_MAX : x;
    endfunction

    function automatic logic [LANES-1:0] exp_sat();
        logic [LANES-1:0] s;
        for (int i = 0; i < LANES; i++) s[i] = (exp_err[i] >= CNT_MAX);
        return s;
    endfunction

    // One clock: inputs in effect at the edge feed the lock model, outputs
    // are then sampled 1 time unit after the edge.
    task automatic tick();
        logic [LANES-1:0] e;
        logic             r;
        e = prbs_err;
        r = reset;
        @(posedge clk);
        #1;
        for (int i = 0; i < LANES; i++) begin
            if (r) begin
                m_clean[i] = 0; m_bad[i] = 0; m_locked[i] = 1'b0;
            end else if (e[i]) begin
                m_clean[i] = 0;
                if (m_bad[i] < UNLOCK_CYCLES) m_bad[i]++;
                if (m_bad[i] >= UNLOCK_CYCLES) m_locked[i] = 1'b0;
            end else begin
                m_bad[i] = 0;
                if (m_clean[i] < LOCK_CYCLES) m_clean[i]++;
                if (m_clean[i] >= LOCK_CYCLES) m_locked[i] = 1'b1;
            end
        end
    endtask

    task automatic clear_model();
        exp_cyc = 0;
        for (int i = 0; i < LANES; i++) exp_err[i] = 0;
    endtask

    // Start a window; errors on the start cycle itself are not counted.
    task automatic begin_run(input int win);
        window_cycles = COUNT_W'(win);
        prbs_err      = LANES'($urandom);
        start         = 1'b1;
        tick();
        start = 1'b0;
        clear_model();
    endtask

    // Drive n counted cycles (mode 0: fixed pattern, 1: random). Optionally
    // raise stop on the last one. Reports done pulses and cycles (other than
    // the last) on which running was low.
    task automatic drive_cycles(input int n, input int mode, input logic [LANES-1:0] pattern,
                                input bit stop_last, output int dones, output int idle);
        dones = 0;
        idle  = 0;
        for (int k = 1; k <= n; k++) begin
            prbs_err = (mode == 0) ? pattern : LANES'($urandom);
            stop     = stop_last && (k == n);
            for (int i = 0; i < LANES; i++) exp_err[i] += int'(prbs_err[i]);
            exp_cyc++;
            tick();
            stop = 1'b0;
            if (done === 1'b1) dones++;
            if (k < n && running !== 1'b1) idle++;
        end
    endtask

    task automatic latch_tick();
        prbs_err = LANES'($urandom);
        tick();
    endtask

    task automatic read_lane(input int s, output logic [COUNT_W-1:0] v);
        lane_sel = SEL_W'(s);
        tick();
        v = rd_err_count;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0; window_cycles = '0; prbs_err = '0; lane_sel = '0;
        tick(); tick();
        reset = 1'b0;
        total++; if (running !== 1'b0) begin bad++; $display("[TB] FAIL reset_running got=%b want=0", running); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rd_valid got=%b want=0", rd_valid); end
        total++; if (rd_err_count !== '0) begin bad++; $display("[TB] FAIL reset_rd_err got=%0d want=0", rd_err_count); end
        total++; if (rd_cycles !== '0) begin bad++; $display("[TB] FAIL reset_rd_cycles got=%0d want=0", rd_cycles); end
        total++; if (lane_locked !== '0) begin bad++; $display("[TB] FAIL reset_locked got=%b want=0", lane_locked); end
        total++; if (lane_saturated !== '0) begin bad++; $display("[TB] FAIL reset_sat got=%b want=0", lane_saturated); end
    endtask

    // Window of 100 with lane0 erroring every cycle.
    task automatic test_window();
        int d, e;
        logic [COUNT_W-1:0] v;
        begin_run(100);
        total++; if (running !== 1'b1) begin bad++; $display("[TB] FAIL win_running got=%b want=1", running); end
        drive_cycles(100, 0, 3'b001, 1'b0, d, e);
        total++; if (d != 0) begin bad++; $display("[TB] FAIL win_early_done got=%0d want=0", d); end
        total++; if (e != 0) begin bad++; $display("[TB] FAIL win_running_drop got=%0d want=0", e); end
        total++; if (running !== 1'b0) begin bad++; $display("[TB] FAIL win_exit got=%b want=0", running); end
        latch_tick();
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL win_done got=%b want=1", done); end
        total++; if (rd_valid !== 1'b1) begin bad++; $display("[TB] FAIL win_rd_valid got=%b want=1", rd_valid); end
        for (int s = 0; s < 4; s++) begin
            read_lane(s, v);
            if (s == 0) begin
                total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL win_done_width got=%b want=0", done); end
                total++; if (rd_cycles !== 8'd100) begin bad++; $display("[TB] FAIL win_rd_cycles got=%0d want=100", rd_cycles); end
            end
            total++;
            if (v !== ((s < LANES) ? COUNT_W'(sat(exp_err[s])) : '0)) begin
                bad++; $display("[TB] FAIL win_lane%0d got=%0d want=%0d", s, v, (s < LANES) ? sat(exp_err[s]) : 0);
            end
        end
        total++; if (lane_saturated !== '0) begin bad++; $display("[TB] FAIL win_sat got=%b want=0", lane_saturated); end
    endtask

    // Open-ended window ended by stop, then random windows with mid-run
    // window_cycles changes (ignored), early stops, and stop on the final cycle.
    task automatic test_stop_and_random();
        int d, e, win, n;
        bit early, use_stop;
        logic [COUNT_W-1:0] v;
        for (int it = 0; it < 7; it++) begin
            if (it == 0) begin
                win = 0; n = 37; use_stop = 1'b1;
            end else begin
                win      = $urandom_range(1, 60);
                early    = ($urandom_range(0, 2) == 0);
                n        = early ? $urandom_range(1, win) : win;
                use_stop = early || ($urandom_range(0, 1) == 1);
            end
            begin_run(win);
            total++; if (rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL rnd%0d_valid_clr got=%b want=0", it, rd_valid); end
            window_cycles = COUNT_W'($urandom_range(1, 255));
            drive_cycles(n, 1, '0, use_stop, d, e);
            total++; if (d != 0 || e != 0) begin bad++; $display("[TB] FAIL rnd%0d_run dones=%0d drops=%0d want 0/0", it, d, e); end
            latch_tick();
            total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL rnd%0d_done got=%b want=1", it, done); end
            for (int s = 0; s < LANES; s++) begin
                read_lane(s, v);
                if (s == 0) begin
                    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL rnd%0d_single_done got=%b want=0", it, done); end
                    total++; if (rd_cycles !== COUNT_W'(n)) begin bad++; $display("[TB] FAIL rnd%0d_cycles got=%0d want=%0d", it, rd_cycles, n); end
                end
                total++; if (v !== COUNT_W'(sat(exp_err[s]))) begin bad++; $display("[TB] FAIL rnd%0d_lane%0d got=%0d want=%0d", it, s, v, sat(exp_err[s])); end
            end
            total++; if (lane_locked !== m_locked) begin bad++; $display("[TB] FAIL rnd%0d_locked got=%b want=%b", it, lane_locked, m_locked); end
        end
    endtask

    // 300 cycles with lane0 always erroring on 8-bit counters.
    task automatic test_saturation();
        int d, e;
        logic [COUNT_W-1:0] v;
        begin_run(0);
        drive_cycles(300, 0, 3'b001, 1'b1, d, e);
        total++; if (d != 0 || e != 0) begin bad++; $display("[TB] FAIL sat_run dones=%0d drops=%0d want 0/0", d, e); end
        latch_tick();
        total++; if (lane_saturated !== exp_sat()) begin bad++; $display("[TB] FAIL sat_flags got=%b want=%b", lane_saturated, exp_sat()); end
        total++; if (lane_saturated !== 3'b001) begin bad++; $display("[TB] FAIL sat_flags_abs got=%b want=001", lane_saturated); end
        read_lane(0, v);
        total++; if (rd_cycles !== 8'd255) begin bad++; $display("[TB] FAIL sat_cycles got=%0d want=255", rd_cycles); end
        total++; if (v !== 8'd255) begin bad++; $display("[TB] FAIL sat_lane0 got=%0d want=255", v); end
        read_lane(1, v);
        total++; if (v !== 8'd0) begin bad++; $display("[TB] FAIL sat_lane1 got=%0d want=0", v); end
    endtask

    // Restart at cycle 50 of a 100-cycle window, with stop in the same cycle.
    task automatic test_restart();
        int d, e;
        logic [COUNT_W-1:0] v;
        begin_run(100);
        drive_cycles(50, 1, '0, 1'b0, d, e);
        stop = 1'b1;
        begin_run(100);
        stop = 1'b0;
        total++; if (running !== 1'b1 || done !== 1'b0) begin bad++; $display("[TB] FAIL rst_start_wins running=%b done=%b want 1/0", running, done); end
        drive_cycles(100, 1, '0, 1'b0, d, e);
        total++; if (d != 0 || e != 0) begin bad++; $display("[TB] FAIL rst_run dones=%0d drops=%0d want 0/0", d, e); end
        latch_tick();
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL rst_done got=%b want=1", done); end
        read_lane(2, v);
        total++; if (rd_cycles !== 8'd100) begin bad++; $display("[TB] FAIL rst_cycles got=%0d want=100", rd_cycles); end
        total++; if (v !== COUNT_W'(sat(exp_err[2]))) begin bad++; $display("[TB] FAIL rst_lane2 got=%0d want=%0d", v, sat(exp_err[2])); end
    endtask

    // start held through LATCH is deferred to IDLE; a start only in LATCH is dropped.
    task automatic test_back_to_back();
        int d, e;
        logic [COUNT_W-1:0] v;
        begin_run(10);
        drive_cycles(10, 1, '0, 1'b0, d, e);
        window_cycles = 8'd20;
        start = 1'b1;
        latch_tick();
        total++; if (done !== 1'b1 || running !== 1'b0) begin bad++; $display("[TB] FAIL b2b_latch done=%b running=%b want 1/0", done, running); end
        tick();
        start = 1'b0;
        clear_model();
        total++; if (running !== 1'b1 || rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_deferred running=%b valid=%b want 1/0", running, rd_valid); end
        drive_cycles(20, 1, '0, 1'b0, d, e);
        total++; if (d != 0 || e != 0) begin bad++; $display("[TB] FAIL b2b_run dones=%0d drops=%0d want 0/0", d, e); end
        latch_tick();
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL b2b_done got=%b want=1", done); end
        read_lane(1, v);
        total++; if (rd_cycles !== 8'd20) begin bad++; $display("[TB] FAIL b2b_cycles got=%0d want=20", rd_cycles); end
        total++; if (v !== COUNT_W'(sat(exp_err[1]))) begin bad++; $display("[TB] FAIL b2b_lane1 got=%0d want=%0d", v, sat(exp_err[1])); end
        begin_run(5);
        drive_cycles(5, 1, '0, 1'b0, d, e);
        start = 1'b1;
        latch_tick();
        start = 1'b0;
        tick();
        total++; if (running !== 1'b0) begin bad++; $display("[TB] FAIL b2b_dropped_start got=%b want=0", running); end
        total++; if (rd_cycles !== 8'd5) begin bad++; $display("[TB] FAIL b2b_cycles5 got=%0d want=5", rd_cycles); end
    endtask

    // Scripted lock thresholds on lane0, then random error-rate phases.
    task automatic test_lock();
        int p [LANES];
        prbs_err = '1;
        for (int k = 0; k < 20; k++) tick();
        prbs_err = 3'b000;
        for (int k = 0; k < 63; k++) tick();
        total++; if (lane_locked[0] !== 1'b0) begin bad++; $display("[TB] FAIL lock_63 got=%b want=0", lane_locked[0]); end
        tick();
        total++; if (lane_locked[0] !== 1'b1) begin bad++; $display("[TB] FAIL lock_64 got=%b want=1", lane_locked[0]); end
        prbs_err = 3'b001;
        for (int k = 0; k < 15; k++) tick();
        prbs_err = 3'b000; tick();
        prbs_err = 3'b001;
        for (int k = 0; k < 15; k++) tick();
        total++; if (lane_locked[0] !== 1'b1) begin bad++; $display("[TB] FAIL lock_hold got=%b want=1", lane_locked[0]); end
        prbs_err = 3'b000; tick();
        prbs_err = 3'b001;
        for (int k = 0; k < 15; k++) tick();
        total++; if (lane_locked[0] !== 1'b1) begin bad++; $display("[TB] FAIL lock_15err got=%b want=1", lane_locked[0]); end
        tick();
        total++; if (lane_locked[0] !== 1'b0) begin bad++; $display("[TB] FAIL lock_16err got=%b want=0", lane_locked[0]); end
        for (int ph = 0; ph < 8; ph++) begin
            for (int i = 0; i < LANES; i++) begin
                case ($urandom_range(0, 3))
                    0: p[i] = 0;
                    1: p[i] = 1;
                    2: p[i] = 50;
                    default: p[i] = 97;
                endcase
            end
            for (int k = 0; k < 90; k++) begin
                for (int i = 0; i < LANES; i++) prbs_err[i] = ($urandom_range(0, 99) < p[i]);
                tick();
                total++; if (lane_locked !== m_locked) begin bad++; $display("[TB] FAIL lock_rnd ph=%0d k=%0d got=%b want=%b", ph, k, lane_locked, m_locked); end
            end
        end
    endtask

    // Reset in the middle of a window, then a fresh 10-cycle window.
    task automatic test_reset_midrun();
        int d, e;
        logic [COUNT_W-1:0] v;
        prbs_err = '0;
        for (int k = 0; k < 70; k++) tick();
        total++; if (lane_locked !== 3'b111) begin bad++; $display("[TB] FAIL rmid_prelock got=%b want=111", lane_locked); end
        begin_run(50);
        drive_cycles(20, 0, 3'b010, 1'b0, d, e);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (running !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL rmid_state running=%b done=%b want 0/0", running, done); end
        total++; if (rd_valid !== 1'b0 || lane_locked !== '0) begin bad++; $display("[TB] FAIL rmid_status valid=%b locked=%b want 0/000", rd_valid, lane_locked); end
        d = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done !== 1'b0) d++;
        end
        total++; if (d != 0) begin bad++; $display("[TB] FAIL rmid_no_done got=%0d want=0", d); end
        begin_run(10);
        drive_cycles(10, 1, '0, 1'b0, d, e);
        latch_tick();
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL rmid_done got=%b want=1", done); end
        read_lane(0, v);
        total++; if (rd_cycles !== 8'd10) begin bad++; $display("[TB] FAIL rmid_cycles got=%0d want=10", rd_cycles); end
        total++; if (v !== COUNT_W'(sat(exp_err[0]))) begin bad++; $display("[TB] FAIL rmid_lane0 got=%0d want=%0d", v, sat(exp_err[0])); end
    endtask

    initial begin
        clear_model();
        test_reset();
        test_window();
        test_stop_and_random();
        test_saturation();
        test_restart();
        test_back_to_back();
        test_lock();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
